// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: reset/exception vectors, the fetch state
// encoding and a word-alignment helper.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC priority mux: exception vector, then taken branch/jump, then a
// pending (delay-slot deferred) redirect, then sequential pc+4.
module npc_sel (
  input  logic [31:0] pc,
  input  logic        exc_take,
  input  logic [31:0] exc_pc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic [31:0] npc
);

  // Highest-priority source wins; pc+4 wraps naturally at 32 bits.
  always_comb begin
    if (exc_take)        npc = exc_pc;
    else if (br_take)    npc = br_target;
    else if (pend_valid) npc = pend_target;
    else                 npc = pc + 32'd4;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues req/ready fetches,
// absorbs decode stalls in a one-entry skid buffer and applies branch
// redirects with delay-slot timing. Drives the IF/ID register.
// Optional feature: define FETCH_EXC_EN to add the exc_req flush port.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] EXC_PC   = cpu_defs::EXC_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_EXC_EN
  ,
  input  logic        exc_req
`endif
);

  import cpu_defs::*;

  fetch_state_e state, state_nxt;

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] br_target_al;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        fire;
  logic        exc_take;

`ifdef FETCH_EXC_EN
  assign exc_take = exc_req;
`else
  assign exc_take = 1'b0;
`endif

  assign br_target_al = align_word(br_target);
  assign fire         = (state == REQ) && imem_ready;
  assign imem_addr    = pc;

  npc_sel u_npc_sel (
    .pc          (pc),
    .exc_take    (exc_take),
    .exc_pc      (EXC_PC),
    .br_take     (br_valid),
    .br_target   (br_target_al),
    .pend_valid  (pend_valid),
    .pend_target (pend_target),
    .npc         (npc)
  );

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // Next-state and request decode; an exception always restarts fetching.
  // NOTE: defaults are assigned first so no path leaves an output unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready && stall) state_nxt = HOLD;
      end
      HOLD: if (!stall) state_nxt = REQ;
      default: state_nxt = BOOT;
    endcase
    if (exc_take) state_nxt = REQ;
  end

  // PC advance and deferred-redirect bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else if (exc_take) begin
      pc         <= npc;
      pend_valid <= 1'b0;
    end else if (fire) begin
      pc         <= npc;
      pend_valid <= 1'b0;
    end else if (br_valid) begin
      if (state == REQ) begin
        // Delay-slot fetch still outstanding: defer the redirect.
        pend_target <= br_target_al;
        pend_valid  <= 1'b1;
      end else if (state == HOLD) begin
        // Delay slot already sits in the skid; pc holds the fall-through.
        pc <= br_target_al;
      end
    end
  end

  // IF/ID register: load on unstalled fire or skid drain, bubble on a miss.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_instr <= 32'd0;
    end else if (exc_take) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (state == REQ) begin
        if_valid <= imem_ready;
        if (imem_ready) begin
          if_pc    <= pc;
          if_instr <= imem_rdata;
        end
      end else if (state == HOLD) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_instr <= skid_instr;
      end
    end
  end

  // Skid capture of a fetch that returned while decode was stalled.
  // NOTE: the skid payload has no reset; it is only read in HOLD, which is
  // entered solely by writing it.
  always_ff @(posedge Clk) begin
    if (fire && stall) begin
      skid_pc    <= pc;
      skid_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. Instruction memory returns
// addr ^ KEY so every delivered word is predictable from its PC.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_EXC_EN
  logic        exc_req;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
`ifdef FETCH_EXC_EN
    ,
    .exc_req    (exc_req)
`endif
  );

  task automatic do_reset;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge Clk);
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", if_valid); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h want 0", if_pc); else passed++;
    total++; if (if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h want 0", if_instr); else passed++;
    total++; if (imem_addr !== 32'h3000) $display("FAIL rst_addr: got %h want 3000", imem_addr); else passed++;
    Reset = 1'b0;
    @(negedge Clk);
    total++; if (imem_req !== 1'b1) $display("FAIL boot_req: got %b want 1", imem_req); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL boot_if_valid: got %b want 0", if_valid); else passed++;
  endtask

  task automatic test_stream_branch;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3004) $display("FAIL seq_addr1: got %h want 3004", imem_addr); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL seq_if_valid: got %b want 1", if_valid); else passed++;
    total++; if (if_pc !== 32'h3000) $display("FAIL seq_if_pc0: got %h want 3000", if_pc); else passed++;
    total++; if (if_instr !== (32'h3000 ^ KEY)) $display("FAIL seq_if_instr0: got %h want %h", if_instr, 32'h3000 ^ KEY); else passed++;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3008) $display("FAIL seq_addr2: got %h want 3008", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3004) $display("FAIL seq_if_pc1: got %h want 3004", if_pc); else passed++;
    br_valid  = 1'b1;
    br_target = 32'h3100;
    @(negedge Clk);
    br_valid = 1'b0;
    total++; if (imem_addr !== 32'h3100) $display("FAIL br_addr: got %h want 3100", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3008) $display("FAIL br_slot_pc: got %h want 3008", if_pc); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL br_slot_valid: got %b want 1", if_valid); else passed++;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3104) $display("FAIL br_after_addr: got %h want 3104", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3100) $display("FAIL br_target_pc: got %h want 3100", if_pc); else passed++;
  endtask

  task automatic test_ready_wait;
    do_reset();
    repeat (4) @(negedge Clk);
    total++; if (imem_addr !== 32'h300C) $display("FAIL wait_addr: got %h want 300c", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3008) $display("FAIL wait_pre_pc: got %h want 3008", if_pc); else passed++;
    imem_ready = 1'b0;
    @(negedge Clk);
    total++; if (if_valid !== 1'b0) $display("FAIL wait_bubble1: got %b want 0", if_valid); else passed++;
    total++; if (imem_addr !== 32'h300C) $display("FAIL wait_hold_addr1: got %h want 300c", imem_addr); else passed++;
    br_valid  = 1'b1;
    br_target = 32'h3200;
    @(negedge Clk);
    br_valid = 1'b0;
    total++; if (if_valid !== 1'b0) $display("FAIL wait_bubble2: got %b want 0", if_valid); else passed++;
    total++; if (imem_addr !== 32'h300C) $display("FAIL wait_hold_addr2: got %h want 300c", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL wait_req: got %b want 1", imem_req); else passed++;
    @(negedge Clk);
    total++; if (if_valid !== 1'b0) $display("FAIL wait_bubble3: got %b want 0", if_valid); else passed++;
    imem_ready = 1'b1;
    @(negedge Clk);
    total++; if (if_valid !== 1'b1) $display("FAIL wait_deliver_valid: got %b want 1", if_valid); else passed++;
    total++; if (if_pc !== 32'h300C) $display("FAIL wait_deliver_pc: got %h want 300c", if_pc); else passed++;
    total++; if (if_instr !== (32'h300C ^ KEY)) $display("FAIL wait_deliver_instr: got %h want %h", if_instr, 32'h300C ^ KEY); else passed++;
    total++; if (imem_addr !== 32'h3200) $display("FAIL pend_redirect: got %h want 3200", imem_addr); else passed++;
  endtask

  task automatic test_stall;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3204) $display("FAIL stall_pre_addr: got %h want 3204", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3200) $display("FAIL stall_pre_pc: got %h want 3200", if_pc); else passed++;
    stall = 1'b1;
    @(negedge Clk);
    total++; if (imem_req !== 1'b0) $display("FAIL stall_req1: got %b want 0", imem_req); else passed++;
    total++; if (if_pc !== 32'h3200) $display("FAIL stall_hold_pc1: got %h want 3200", if_pc); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL stall_hold_valid: got %b want 1", if_valid); else passed++;
    @(negedge Clk);
    total++; if (imem_req !== 1'b0) $display("FAIL stall_req2: got %b want 0", imem_req); else passed++;
    total++; if (if_pc !== 32'h3200) $display("FAIL stall_hold_pc2: got %h want 3200", if_pc); else passed++;
    stall = 1'b0;
    @(negedge Clk);
    total++; if (if_pc !== 32'h3204) $display("FAIL skid_pc: got %h want 3204", if_pc); else passed++;
    total++; if (if_instr !== (32'h3204 ^ KEY)) $display("FAIL skid_instr: got %h want %h", if_instr, 32'h3204 ^ KEY); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL skid_valid: got %b want 1", if_valid); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL skid_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h3208) $display("FAIL skid_next_addr: got %h want 3208", imem_addr); else passed++;
  endtask

  task automatic test_hold_branch;
    stall = 1'b1;
    @(negedge Clk);
    total++; if (imem_req !== 1'b0) $display("FAIL hbr_req: got %b want 0", imem_req); else passed++;
    br_valid  = 1'b1;
    br_target = 32'h3303;
    @(negedge Clk);
    br_valid = 1'b0;
    stall    = 1'b0;
    total++; if (if_pc !== 32'h3204) $display("FAIL hbr_hold_pc: got %h want 3204", if_pc); else passed++;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3300) $display("FAIL hbr_aligned_addr: got %h want 3300", imem_addr); else passed++;
    total++; if (if_pc !== 32'h3208) $display("FAIL hbr_slot_pc: got %h want 3208", if_pc); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL hbr_slot_valid: got %b want 1", if_valid); else passed++;
  endtask

  task automatic test_reset_mid_hold;
    stall = 1'b1;
    @(negedge Clk);
    total++; if (imem_req !== 1'b0) $display("FAIL rhold_req: got %b want 0", imem_req); else passed++;
    Reset = 1'b1;
    @(negedge Clk);
    total++; if (if_valid !== 1'b0) $display("FAIL rhold_valid: got %b want 0", if_valid); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL rhold_if_pc: got %h want 0", if_pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL rhold_boot_req: got %b want 0", imem_req); else passed++;
    Reset = 1'b0;
    stall = 1'b0;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h3000) $display("FAIL rhold_addr: got %h want 3000", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL rhold_restart_req: got %b want 1", imem_req); else passed++;
  endtask

  task automatic test_wrap;
    br_valid  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    @(negedge Clk);
    br_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want fffffffc", imem_addr); else passed++;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_zero: got %h want 0", imem_addr); else passed++;
    total++; if (if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc: got %h want fffffffc", if_pc); else passed++;
    @(negedge Clk);
    total++; if (imem_addr !== 32'h4) $display("FAIL wrap_next: got %h want 4", imem_addr); else passed++;
  endtask

`ifdef FETCH_EXC_EN
  task automatic test_exc;
    exc_req   = 1'b1;
    br_valid  = 1'b1;
    br_target = 32'h5000;
    @(negedge Clk);
    exc_req  = 1'b0;
    br_valid = 1'b0;
    total++; if (if_valid !== 1'b0) $display("FAIL exc_flush_valid: got %b want 0", if_valid); else passed++;
    total++; if (imem_addr !== 32'h4180) $display("FAIL exc_addr: got %h want 4180", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL exc_req_out: got %b want 1", imem_req); else passed++;
    @(negedge Clk);
    total++; if (if_pc !== 32'h4180) $display("FAIL exc_if_pc: got %h want 4180", if_pc); else passed++;
    total++; if (imem_addr !== 32'h4184) $display("FAIL exc_next: got %h want 4184", imem_addr); else passed++;
  endtask
`endif

  initial begin
    Reset      = 1'b1;
    stall      = 1'b0;
    br_valid   = 1'b0;
    br_target  = 32'h0;
    imem_ready = 1'b1;
`ifdef FETCH_EXC_EN
    exc_req    = 1'b0;
`endif
    test_reset();
    test_stream_branch();
    test_ready_wait();
    test_stall();
    test_hold_branch();
    test_reset_mid_hold();
    test_wrap();
`ifdef FETCH_EXC_EN
    test_exc();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
